// File: rtl/mvp_pll_pkg.sv
// Shared definitions for the multi-VCO PLL sequencer: state encodings and
// the largest VCO count the select logic is sized for.
package mvp_pll_pkg;

  localparam int MAX_VCO = 8;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_BIAS_SETTLE  = 4'd1,
    ST_FASTLOCKING  = 4'd2,
    ST_PRE_LOCKING  = 4'd3,
    ST_LOCKING      = 4'd4,
    ST_PLL_LOCKED   = 4'd5,
    ST_PRE_SWITCH   = 4'd6,
    ST_SWITCH_RESET = 4'd7,
    ST_SWITCH_1     = 4'd8,
    ST_SWITCH_2     = 4'd9,
    ST_LOCK_FAIL    = 4'd10
  } pll_state_t;

endpackage

// File: rtl/mvp_pll_multi_sm_if.sv
// Signal bundle between a PLL controller (master) and the sequencer (slave):
// control/config toward the sequencer, analog controls and status back.
interface mvp_pll_multi_sm_if #(
  parameter int NUM_VCO = 3,
  parameter int VSEL_W  = 2,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input logic clk
);
  logic               enable;
  logic [VSEL_W-1:0]  core_vco_sel;
  logic               locked;
  logic               core_switch_vco;
  logic [CNT_W-1:0]   cfg_bias_settle_count;
  logic [CNT_W-1:0]   cfg_pre_locking_count;
  logic [CNT_W-1:0]   cfg_pre_switch_time;
  logic [CNT_W-1:0]   cfg_switch_reset_time;
  logic [CNT_W-1:0]   cfg_switch_time;
  logic [TO_W-1:0]    cfg_lock_timeout;
  logic [2:0]         cfg_max_retries;
  logic [3:0]         cfg_lol_debounce;
  logic               cfg_lol_relock;
  logic               cfg_disable_lock_det_after_lock;
  logic               en_lock_det;
  logic               en_fastlock;
  logic               pll_reset;
  logic               enable_fbclk;
  logic               fastlock_ready;
  logic               vctrl_locked;
  logic               switch_done;
  logic [NUM_VCO-1:0] vco_en;
  logic [VSEL_W-1:0]  vco_sel;
  logic [VSEL_W-1:0]  vco_gfcm_sel;
  logic               ready;
  logic               loss_of_lock;
  logic               lock_fail;
  logic [2:0]         retry_count;
  logic [3:0]         fsm_state;

  modport master (
    input  clk,
    output enable, core_vco_sel, locked, core_switch_vco,
    output cfg_bias_settle_count, cfg_pre_locking_count, cfg_pre_switch_time,
    output cfg_switch_reset_time, cfg_switch_time, cfg_lock_timeout,
    output cfg_max_retries, cfg_lol_debounce, cfg_lol_relock,
    output cfg_disable_lock_det_after_lock,
    input  en_lock_det, en_fastlock, pll_reset, enable_fbclk, fastlock_ready,
    input  vctrl_locked, switch_done, vco_en, vco_sel, vco_gfcm_sel,
    input  ready, loss_of_lock, lock_fail, retry_count, fsm_state
  );

  modport slave (
    input  clk,
    input  enable, core_vco_sel, locked, core_switch_vco,
    input  cfg_bias_settle_count, cfg_pre_locking_count, cfg_pre_switch_time,
    input  cfg_switch_reset_time, cfg_switch_time, cfg_lock_timeout,
    input  cfg_max_retries, cfg_lol_debounce, cfg_lol_relock,
    input  cfg_disable_lock_det_after_lock,
    output en_lock_det, en_fastlock, pll_reset, enable_fbclk, fastlock_ready,
    output vctrl_locked, switch_done, vco_en, vco_sel, vco_gfcm_sel,
    output ready, loss_of_lock, lock_fail, retry_count, fsm_state
  );
endinterface

// File: rtl/demet_reset.sv
// Two-flop synchroniser with asynchronous active-high reset, clearing to 0.
module demet_reset #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/mvp_pll_multi_sm.sv
// Multi-VCO PLL power-up, lock, retry and VCO-switch sequencer.
// Asynchronous inputs are synchronised; all analog controls are registered.
module mvp_pll_multi_sm
  import mvp_pll_pkg::*;
#(
  parameter int NUM_VCO = 3,
  parameter int VSEL_W  = 2,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [VSEL_W-1:0]  core_vco_sel,
  input  logic               locked,
  input  logic               core_switch_vco,
  input  logic [CNT_W-1:0]   cfg_bias_settle_count,
  input  logic [CNT_W-1:0]   cfg_pre_locking_count,
  input  logic [CNT_W-1:0]   cfg_pre_switch_time,
  input  logic [CNT_W-1:0]   cfg_switch_reset_time,
  input  logic [CNT_W-1:0]   cfg_switch_time,
  input  logic [TO_W-1:0]    cfg_lock_timeout,
  input  logic [2:0]         cfg_max_retries,
  input  logic [3:0]         cfg_lol_debounce,
  input  logic               cfg_lol_relock,
  input  logic               cfg_disable_lock_det_after_lock,
  output logic               en_lock_det,
  output logic               en_fastlock,
  output logic               pll_reset,
  output logic               enable_fbclk,
  output logic               fastlock_ready,
  output logic               vctrl_locked,
  output logic               switch_done,
  output logic [NUM_VCO-1:0] vco_en,
  output logic [VSEL_W-1:0]  vco_sel,
  output logic [VSEL_W-1:0]  vco_gfcm_sel,
  output logic               ready,
  output logic               loss_of_lock,
  output logic               lock_fail,
  output logic [2:0]         retry_count,
  output logic [3:0]         fsm_state
);
  localparam logic [VSEL_W:0] NUM_VCO_L = (VSEL_W+1)'(NUM_VCO);

  logic [VSEL_W+1:0]  w_sync;
  logic               w_en;
  logic               w_lock;
  logic [VSEL_W-1:0]  w_sel_raw;
  logic [VSEL_W-1:0]  w_sel;
  logic [NUM_VCO-1:0] w_oh_req;
  logic [NUM_VCO-1:0] w_oh_cur;
  logic               w_timeout;

  pll_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [3:0]         r_lol_cnt;
  logic [VSEL_W-1:0]  r_new_sel;
  logic               r_en_lock_det, r_en_fastlock, r_pll_reset, r_enable_fbclk;
  logic               r_fastlock_ready, r_vctrl_locked, r_switch_done;
  logic               r_loss_of_lock, r_lock_fail;
  logic [NUM_VCO-1:0] r_vco_en;
  logic [VSEL_W-1:0]  r_vco_sel, r_vco_gfcm_sel;
  logic [2:0]         r_retry;

  demet_reset #(.WIDTH(VSEL_W + 2)) u_demet (
    .clk   (clk),
    .reset (reset),
    .i_d   ({enable, locked, core_vco_sel}),
    .o_q   (w_sync)
  );

  assign w_en      = w_sync[VSEL_W+1];
  assign w_lock    = w_sync[VSEL_W];
  assign w_sel_raw = w_sync[VSEL_W-1:0];
  // Selects that name a non-existent VCO fall back to VCO0.
  assign w_sel     = ({1'b0, w_sel_raw} >= NUM_VCO_L) ? '0 : w_sel_raw;
  assign w_timeout = (cfg_lock_timeout != '0) && (r_to_cnt == cfg_lock_timeout - TO_W'(1));

  for (genvar gi = 0; gi < NUM_VCO; gi++) begin : g_onehot
    assign w_oh_req[gi] = (w_sel == VSEL_W'(gi));
    assign w_oh_cur[gi] = (r_vco_sel == VSEL_W'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_to_cnt <= '0;
      r_lol_cnt <= '0;
      r_new_sel <= '0;
      r_en_lock_det <= 1'b0;
      r_en_fastlock <= 1'b0;
      r_pll_reset <= 1'b1;
      r_enable_fbclk <= 1'b0;
      r_fastlock_ready <= 1'b0;
      r_vctrl_locked <= 1'b0;
      r_switch_done <= 1'b0;
      r_loss_of_lock <= 1'b0;
      r_lock_fail <= 1'b0;
      r_vco_en <= '0;
      r_vco_sel <= '0;
      r_vco_gfcm_sel <= '0;
      r_retry <= '0;
    end else begin
      r_loss_of_lock <= 1'b0;
      if (r_state != ST_IDLE && !w_en) begin
        r_state <= ST_IDLE;
        r_cnt <= '0;
        r_to_cnt <= '0;
        r_lol_cnt <= '0;
        r_en_lock_det <= 1'b0;
        r_en_fastlock <= 1'b0;
        r_fastlock_ready <= 1'b0;
        r_lock_fail <= 1'b0;
        r_pll_reset <= 1'b1;
        r_enable_fbclk <= 1'b0;
        r_vctrl_locked <= 1'b0;
        r_vco_en <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            r_to_cnt <= '0;
            r_pll_reset <= 1'b1;
            r_enable_fbclk <= 1'b0;
            r_vctrl_locked <= 1'b0;
            r_vco_en <= '0;
            if (w_en) begin
              r_vco_sel <= w_sel;
              r_vco_gfcm_sel <= w_sel;
              r_vco_en <= w_oh_req;
              r_pll_reset <= 1'b0;
              r_enable_fbclk <= 1'b1;
              r_retry <= '0;
              r_state <= ST_BIAS_SETTLE;
            end
          end
          ST_BIAS_SETTLE: begin
            // Also terminates the one-cycle reset pulse issued on a retry.
            r_pll_reset <= 1'b0;
            if (r_cnt == cfg_bias_settle_count) begin
              r_cnt <= '0;
              r_to_cnt <= '0;
              r_en_lock_det <= 1'b1;
              r_en_fastlock <= 1'b1;
              r_state <= ST_FASTLOCKING;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_FASTLOCKING, ST_LOCKING: begin
            if (w_lock) begin
              r_to_cnt <= '0;
              if (r_state == ST_FASTLOCKING) begin
                r_en_lock_det <= 1'b0;
                r_en_fastlock <= 1'b0;
                r_fastlock_ready <= 1'b1;
                r_cnt <= '0;
                r_state <= ST_PRE_LOCKING;
              end else begin
                r_vctrl_locked <= 1'b1;
                r_en_lock_det <= ~cfg_disable_lock_det_after_lock;
                r_lol_cnt <= '0;
                r_state <= ST_PLL_LOCKED;
              end
            end else if (w_timeout) begin
              r_to_cnt <= '0;
              r_cnt <= '0;
              r_en_lock_det <= 1'b0;
              r_en_fastlock <= 1'b0;
              r_pll_reset <= 1'b1;
              if (r_retry < cfg_max_retries) begin
                r_retry <= r_retry + 3'd1;
                r_state <= ST_BIAS_SETTLE;
              end else begin
                r_enable_fbclk <= 1'b0;
                r_lock_fail <= 1'b1;
                r_state <= ST_LOCK_FAIL;
              end
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          ST_PRE_LOCKING: begin
            r_en_lock_det <= 1'b0;
            if (r_cnt == cfg_pre_locking_count) begin
              r_cnt <= '0;
              r_to_cnt <= '0;
              r_en_lock_det <= 1'b1;
              r_state <= ST_LOCKING;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_PLL_LOCKED: begin
            r_en_lock_det <= ~cfg_disable_lock_det_after_lock;
            // A switch request takes priority over a coincident loss of lock.
            if (core_switch_vco) begin
              r_enable_fbclk <= 1'b0;
              r_en_lock_det <= 1'b0;
              r_fastlock_ready <= 1'b0;
              r_switch_done <= 1'b0;
              r_vctrl_locked <= 1'b0;
              r_new_sel <= w_sel;
              r_vco_en <= r_vco_en | w_oh_req;
              r_cnt <= '0;
              r_state <= ST_PRE_SWITCH;
            end else if (!w_lock) begin
              if (r_lol_cnt == cfg_lol_debounce) begin
                r_loss_of_lock <= 1'b1;
                r_lol_cnt <= '0;
                if (cfg_lol_relock) begin
                  r_en_lock_det <= 1'b1;
                  r_vctrl_locked <= 1'b0;
                  r_to_cnt <= '0;
                  r_state <= ST_LOCKING;
                end
              end else begin
                r_lol_cnt <= r_lol_cnt + 4'd1;
              end
            end else begin
              r_lol_cnt <= '0;
            end
          end
          ST_PRE_SWITCH: begin
            if (r_cnt == cfg_pre_switch_time) begin
              r_cnt <= '0;
              r_pll_reset <= 1'b1;
              r_vco_sel <= r_new_sel;
              r_state <= ST_SWITCH_RESET;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_SWITCH_RESET: begin
            if (r_cnt == cfg_switch_reset_time) begin
              r_cnt <= '0;
              r_pll_reset <= 1'b0;
              r_state <= ST_SWITCH_1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_SWITCH_1: begin
            if (r_cnt == cfg_switch_time) begin
              r_cnt <= '0;
              r_vco_gfcm_sel <= r_vco_sel;
              r_state <= ST_SWITCH_2;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_SWITCH_2: begin
            if (r_cnt == cfg_switch_time) begin
              r_cnt <= '0;
              r_to_cnt <= '0;
              r_vco_en <= w_oh_cur;
              r_en_lock_det <= 1'b1;
              r_enable_fbclk <= 1'b1;
              r_switch_done <= 1'b1;
              r_state <= ST_LOCKING;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_LOCK_FAIL: begin
            r_pll_reset <= 1'b1;
            r_enable_fbclk <= 1'b0;
            r_en_lock_det <= 1'b0;
            r_lock_fail <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign en_lock_det    = r_en_lock_det;
  assign en_fastlock    = r_en_fastlock;
  assign pll_reset      = r_pll_reset;
  assign enable_fbclk   = r_enable_fbclk;
  assign fastlock_ready = r_fastlock_ready;
  assign vctrl_locked   = r_vctrl_locked;
  assign switch_done    = r_switch_done;
  assign vco_en         = r_vco_en;
  assign vco_sel        = r_vco_sel;
  assign vco_gfcm_sel   = r_vco_gfcm_sel;
  assign loss_of_lock   = r_loss_of_lock;
  assign lock_fail      = r_lock_fail;
  assign retry_count    = r_retry;
  assign ready          = (r_state == ST_PLL_LOCKED);
  assign fsm_state      = r_state;
endmodule

// File: tb/tb_mvp_pll_multi_sm.sv
// Directed bench for the multi-VCO PLL sequencer: bring-up latency, retries,
// loss-of-lock debounce, VCO switching, enable drop and select clamping.
module tb_mvp_pll_multi_sm;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mvp_pll_multi_sm_if #(.NUM_VCO(3), .VSEL_W(2), .CNT_W(8), .TO_W(16)) bus (.clk(clk));

  mvp_pll_multi_sm #(.NUM_VCO(3), .VSEL_W(2), .CNT_W(8), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .enable(bus.enable), .core_vco_sel(bus.core_vco_sel),
    .locked(bus.locked), .core_switch_vco(bus.core_switch_vco),
    .cfg_bias_settle_count(bus.cfg_bias_settle_count), .cfg_pre_locking_count(bus.cfg_pre_locking_count),
    .cfg_pre_switch_time(bus.cfg_pre_switch_time), .cfg_switch_reset_time(bus.cfg_switch_reset_time),
    .cfg_switch_time(bus.cfg_switch_time), .cfg_lock_timeout(bus.cfg_lock_timeout),
    .cfg_max_retries(bus.cfg_max_retries), .cfg_lol_debounce(bus.cfg_lol_debounce),
    .cfg_lol_relock(bus.cfg_lol_relock), .cfg_disable_lock_det_after_lock(bus.cfg_disable_lock_det_after_lock),
    .en_lock_det(bus.en_lock_det), .en_fastlock(bus.en_fastlock), .pll_reset(bus.pll_reset),
    .enable_fbclk(bus.enable_fbclk), .fastlock_ready(bus.fastlock_ready), .vctrl_locked(bus.vctrl_locked),
    .switch_done(bus.switch_done), .vco_en(bus.vco_en), .vco_sel(bus.vco_sel), .vco_gfcm_sel(bus.vco_gfcm_sel),
    .ready(bus.ready), .loss_of_lock(bus.loss_of_lock), .lock_fail(bus.lock_fail),
    .retry_count(bus.retry_count), .fsm_state(bus.fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.core_vco_sel = 2'd0; bus.locked = 1'b0; bus.core_switch_vco = 1'b0;
    bus.cfg_bias_settle_count = 8'd4; bus.cfg_pre_locking_count = 8'd2;
    bus.cfg_pre_switch_time = 8'd2; bus.cfg_switch_reset_time = 8'd3; bus.cfg_switch_time = 8'd2;
    bus.cfg_lock_timeout = 16'd0; bus.cfg_max_retries = 3'd2; bus.cfg_lol_debounce = 4'd4;
    bus.cfg_lol_relock = 1'b0; bus.cfg_disable_lock_det_after_lock = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic bring_up(output int n);
    bus.locked = 1'b1;
    bus.enable = 1'b1;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin tick(); n++; end
  endtask

  task automatic wait_state(input logic [3:0] st, input int limit, output int n);
    n = 0;
    while (bus.fsm_state !== st && n < limit) begin tick(); n++; end
  endtask

  task automatic test_reset();
    logic [9:0]  flags;
    logic [13:0] vecs;
    reset = 1'b1;
    do_reset();
    reset = 1'b1;
    tick();
    flags = {bus.pll_reset, bus.en_lock_det, bus.en_fastlock, bus.enable_fbclk, bus.fastlock_ready,
             bus.vctrl_locked, bus.switch_done, bus.ready, bus.loss_of_lock, bus.lock_fail};
    vecs  = {bus.vco_en, bus.vco_sel, bus.vco_gfcm_sel, bus.retry_count, bus.fsm_state};
    checks++; if (flags !== 10'b1000000000) begin errors++; $display("FAIL reset_flags: got %b expected %b", flags, 10'b1000000000); end
    checks++; if (vecs !== 14'd0) begin errors++; $display("FAIL reset_vectors: got %h expected 0", vecs); end
    reset = 1'b0;
    repeat (5) tick();
    checks++; if (bus.fsm_state !== 4'd0) begin errors++; $display("FAIL idle_without_enable: got %0d expected 0", bus.fsm_state); end
  endtask

  task automatic test_lock_up();
    int n;
    do_reset();
    bring_up(n);
    checks++; if (n !== 13) begin errors++; $display("FAIL lock_latency: got %0d expected 13", n); end
    checks++; if (bus.vco_en !== 3'b001) begin errors++; $display("FAIL lock_vco_en: got %b expected 001", bus.vco_en); end
    checks++; if ({bus.vctrl_locked, bus.fastlock_ready, bus.en_lock_det, bus.en_fastlock, bus.pll_reset, bus.enable_fbclk} !== 6'b111001)
      begin errors++; $display("FAIL lock_controls: got %b expected 111001",
        {bus.vctrl_locked, bus.fastlock_ready, bus.en_lock_det, bus.en_fastlock, bus.pll_reset, bus.enable_fbclk}); end
    checks++; if (bus.fsm_state !== 4'd5) begin errors++; $display("FAIL lock_state: got %0d expected 5", bus.fsm_state); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus.fsm_state, bus.pll_reset, bus.vco_en} !== {4'd0, 1'b1, 3'b000})
      begin errors++; $display("FAIL async_reset: got state %0d pll_reset %b vco_en %b expected 0 1 000", bus.fsm_state, bus.pll_reset, bus.vco_en); end
    tick();
    reset = 1'b0;
    bring_up(n);
    checks++; if (n !== 13) begin errors++; $display("FAIL relock_after_reset: got %0d expected 13", n); end
  endtask

  task automatic test_timeout();
    int n, pulses;
    do_reset();
    bus.cfg_lock_timeout = 16'd20;
    bus.locked = 1'b0;
    bus.enable = 1'b1;
    n = 0; pulses = 0;
    while (bus.fsm_state !== 4'd10 && n < 300) begin
      tick(); n++;
      if (bus.pll_reset === 1'b1 && bus.fsm_state !== 4'd10 && bus.fsm_state !== 4'd0) pulses++;
    end
    checks++; if (n !== 78) begin errors++; $display("FAIL lock_fail_cycles: got %0d expected 78", n); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL retry_pulse_cycles: got %0d expected 2", pulses); end
    checks++; if ({bus.lock_fail, bus.retry_count, bus.pll_reset, bus.enable_fbclk, bus.en_lock_det} !== {1'b1, 3'd2, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL lock_fail_outputs: got lf %b retry %0d rst %b fb %b ld %b expected 1 2 1 0 0",
        bus.lock_fail, bus.retry_count, bus.pll_reset, bus.enable_fbclk, bus.en_lock_det); end
    bus.enable = 1'b0;
    wait_state(4'd0, 6, n);
    checks++; if (n !== 3 || bus.lock_fail !== 1'b0) begin errors++; $display("FAIL lock_fail_exit: got %0d cycles lock_fail %b expected 3 0", n, bus.lock_fail); end
  endtask

  task automatic test_timeout_disabled();
    do_reset();
    bus.locked = 1'b0;
    bus.enable = 1'b1;
    repeat (100) tick();
    checks++; if ({bus.fsm_state, bus.retry_count, bus.pll_reset} !== {4'd2, 3'd0, 1'b0})
      begin errors++; $display("FAIL no_timeout: got state %0d retry %0d rst %b expected 2 0 0", bus.fsm_state, bus.retry_count, bus.pll_reset); end
  endtask

  task automatic test_loss_of_lock();
    int n, pulses;
    logic [3:0] st_at;
    do_reset();
    bring_up(n);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin bus.locked = (i >= 3); tick(); if (bus.loss_of_lock === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL lol_short_glitch: got %0d expected 0", pulses); end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin bus.locked = (i >= 6); tick(); if (bus.loss_of_lock === 1'b1) pulses++; end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL lol_long_drop: got %0d expected 1", pulses); end
    checks++; if (bus.fsm_state !== 4'd5) begin errors++; $display("FAIL lol_stay_locked: got %0d expected 5", bus.fsm_state); end
    bus.cfg_lol_relock = 1'b1;
    pulses = 0; st_at = 4'hf;
    for (int i = 0; i < 16; i++) begin
      bus.locked = (i >= 6); tick();
      if (bus.loss_of_lock === 1'b1) begin pulses++; st_at = bus.fsm_state; end
    end
    checks++; if (pulses !== 1 || st_at !== 4'd4) begin errors++; $display("FAIL lol_relock: got %0d pulses state %0d expected 1 4", pulses, st_at); end
    checks++; if (bus.fsm_state !== 4'd5) begin errors++; $display("FAIL lol_relocked: got %0d expected 5", bus.fsm_state); end
  endtask

  task automatic test_switch();
    int n, n6;
    do_reset();
    bring_up(n);
    bus.core_vco_sel = 2'd2;
    repeat (3) tick();
    bus.core_switch_vco = 1'b1; tick(); bus.core_switch_vco = 1'b0;
    checks++; if ({bus.fsm_state, bus.vco_en} !== {4'd6, 3'b101}) begin errors++; $display("FAIL pre_switch_vco_en: got state %0d vco_en %b expected 6 101", bus.fsm_state, bus.vco_en); end
    checks++; if ({bus.enable_fbclk, bus.switch_done, bus.fastlock_ready, bus.en_lock_det} !== 4'b0000)
      begin errors++; $display("FAIL pre_switch_controls: got %b expected 0000", {bus.enable_fbclk, bus.switch_done, bus.fastlock_ready, bus.en_lock_det}); end
    n6 = 0; n = 0;
    while (bus.fsm_state === 4'd6 && n < 20) begin n6++; tick(); n++; end
    checks++; if (n6 !== 3) begin errors++; $display("FAIL pre_switch_length: got %0d expected 3", n6); end
    checks++; if ({bus.fsm_state, bus.vco_sel, bus.pll_reset} !== {4'd7, 2'd2, 1'b1})
      begin errors++; $display("FAIL switch_reset: got state %0d sel %0d rst %b expected 7 2 1", bus.fsm_state, bus.vco_sel, bus.pll_reset); end
    wait_state(4'd4, 40, n);
    checks++; if ({bus.fsm_state, bus.vco_en, bus.vco_gfcm_sel, bus.switch_done, bus.enable_fbclk, bus.en_lock_det} !== {4'd4, 3'b100, 2'd2, 3'b111})
      begin errors++; $display("FAIL switch_done_out: got state %0d vco_en %b gfcm %0d done/fb/ld %b expected 4 100 2 111",
        bus.fsm_state, bus.vco_en, bus.vco_gfcm_sel, {bus.switch_done, bus.enable_fbclk, bus.en_lock_det}); end
    wait_state(4'd5, 10, n);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL switch_relock: got ready %b expected 1", bus.ready); end
  endtask

  task automatic test_enable_drop();
    int n;
    do_reset();
    bus.cfg_switch_time = 8'd6;
    bring_up(n);
    bus.core_vco_sel = 2'd1;
    repeat (3) tick();
    bus.core_switch_vco = 1'b1; tick(); bus.core_switch_vco = 1'b0;
    wait_state(4'd8, 40, n);
    checks++; if (bus.fsm_state !== 4'd8) begin errors++; $display("FAIL reach_switch_1: got %0d expected 8", bus.fsm_state); end
    bus.enable = 1'b0;
    wait_state(4'd0, 6, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL drop_latency: got %0d expected 3", n); end
    checks++; if ({bus.pll_reset, bus.vco_en, bus.en_lock_det, bus.fastlock_ready, bus.enable_fbclk} !== {1'b1, 3'b000, 3'b000})
      begin errors++; $display("FAIL drop_outputs: got rst %b vco_en %b ld/fr/fb %b expected 1 000 000",
        bus.pll_reset, bus.vco_en, {bus.en_lock_det, bus.fastlock_ready, bus.enable_fbclk}); end
  endtask

  task automatic test_out_of_range();
    int n;
    do_reset();
    bus.core_vco_sel = 2'd3;
    bring_up(n);
    checks++; if ({bus.ready, bus.vco_en, bus.vco_sel, bus.vco_gfcm_sel} !== {1'b1, 3'b001, 2'd0, 2'd0})
      begin errors++; $display("FAIL sel_clamp: got ready %b vco_en %b sel %0d gfcm %0d expected 1 001 0 0",
        bus.ready, bus.vco_en, bus.vco_sel, bus.vco_gfcm_sel); end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_timeout();
    test_timeout_disabled();
    test_loss_of_lock();
    test_switch();
    test_enable_drop();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
